gf180mcu_fd_sc_mcu7t5v0__rstseq: RTL
====================================

# gf180mcu_fd_sc_mcu7t5v0__rstseq

Reset sequencer that sits directly upstream of banks of `dffrnq` flops and drives their `RN` pins. It asserts reset asynchronously and releases it synchronously. Release happens after a programmable stretch, and domains are released one at a time at a fixed spacing. A registered `READY` flag reports that every domain is out of reset.

## Interface
- `SYNC_STAGES`, default 2: depth of the deassertion synchronizer; legal range 2..4.
- `STRETCH`, default 16: clock edges held in reset after the synchronizer output rises; legal range 1..255.
- `GAP`, default 4: clock edges between consecutive domain releases; legal range 1..255.
- `NDOM`, default 4: number of reset domains; legal range 1..8.
- `CLK` input 1: single clock; all state advances on the rising edge.
- `RN` input 1: reset, asynchronous and active-low; clears all state immediately.
- `SWRN` input 1: soft reset request, active-low, synchronous to `CLK`.
- `RNO` output `NDOM`: per-domain active-low reset to downstream `RN` pins; driven directly from flops.
- `READY` output 1: high when all `RNO` bits are 1; registered.

## Operation
- All flops use the asynchronous active-low `RN`. There is no other asynchronous input.
- Reset values while `RN`=0: synchronizer chain all 0, state HOLD, counter 0, domain index 0, `RNO`=0, `READY`=0.
- Synchronizer:
  - `SYNC_STAGES` flops, first D tied to 1.
  - Output `sync` rises after the `SYNC_STAGES`-th rising edge following `RN` deassertion.
- States:
  - HOLD: counter increments on each edge with `sync`=1 and `SWRN`=1, and holds at 0 while `SWRN`=0. On the edge where the counter reaches `STRETCH`: set `RNO[0]`=1, clear the counter, and go to RELEASE (or RUN if `NDOM`=1).
  - RELEASE: counter increments every edge. On reaching `GAP`: set the next `RNO` bit (ascending index) and clear the counter. After setting `RNO[NDOM-1]`, go to RUN.
  - RUN: hold all outputs; `READY`=1.
- `READY` is set on the same edge that sets `RNO[NDOM-1]`.
- Soft reset: if `SWRN`=0 is sampled in HOLD, RELEASE or RUN, then on that edge:
  - `RNO` goes to all 0, `READY`=0, counter is cleared, domain index is cleared, state becomes HOLD.
- `SWRN` has priority over any release scheduled on the same edge.
- `RNO` bits only ever go 0→1 in ascending order. They return to 0 only all together, via `RN` or `SWRN`.
- Counter width is ceil(log2(max(`STRETCH`,`GAP`)+1)) bits. The counter never wraps, because it clears at its terminal value.

## Timing
- Edge numbering: edge n is the n-th rising `CLK` edge after `RN` deasserts, with recovery met. S=`SYNC_STAGES`.
- `sync`=1 after edge S. With `SWRN`=1 throughout:
  - `RNO[0]` rises after edge S+`STRETCH`.
  - `RNO[i]` rises after edge S+`STRETCH`+i·`GAP`.
  - `READY` rises together with `RNO[NDOM-1]`.
- With the defaults, `RNO` bits rise after edges 18, 22, 26 and 30; `READY` rises after edge 30.
- `RN` falling at any time: `RNO` and `READY` go to 0 without a clock (only clock-to-Q of the reset arc), in any state including mid-release.
- Soft reset: if `SWRN`=0 is sampled at edge m, outputs are 0 after edge m. If edge p is the first edge that samples `SWRN`=1 again, `RNO[0]` rises after edge p+`STRETCH`-1, and later domains follow at `GAP` spacing.
- `SWRN` low before `sync` rises: HOLD count stays at 0 until `SWRN` is high; the synchronizer is unaffected.
- Outputs never glitch: each `RNO` bit comes from its own flop, with no combinational logic after it.

## Test plan
- Power-up: defaults, `RN` low for 3 cycles then high, `SWRN`=1 → `RNO` goes 0001 after edge 18, 0011 after edge 22, 0111 after edge 26, 1111 after edge 30; `READY`=1 after edge 30.
- Async reset mid-release: drop `RN` between edges 23 and 24 (`RNO`=0011) → `RNO`=0000 and `READY`=0 before edge 24. On re-release, the power-up sequence repeats exactly.
- Soft reset in RUN: `SWRN`=0 sampled at edge 40 and held for 5 edges → `RNO`=0 after edge 40. First high sample is at edge 45, so `RNO[0]` rises after edge 60 and `READY` after edge 72.
- Simultaneous events: `SWRN`=0 sampled on the edge that would release `RNO[2]` → `RNO`=0000, state HOLD, `RNO[2]` never rises.
- Parameters: `SYNC_STAGES`=3, `STRETCH`=1, `GAP`=1, `NDOM`=1 → `RNO[0]` and `READY` rise after edge 4.
- Parameters: `NDOM`=8, `GAP`=255 → releases are exactly 255 edges apart and the counter never exceeds 255.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rstseq.sv
// Reset sequencer for banks of dffrnq flops.
//
// Reset is asserted asynchronously through RN. It is released synchronously:
// a SYNC_STAGES-deep chain first synchronizes the RN release. The block then
// waits STRETCH edges and releases RNO[0]. It then releases RNO[1..NDOM-1] in
// ascending order, one every GAP edges. READY is a registered flag. It rises
// on the same edge that releases the last domain.
//
// Ports:
//   CLK   - single clock, rising edge
//   RN    - asynchronous active-low reset, clears all state
//   SWRN  - synchronous active-low soft reset request
//   RNO   - per-domain active-low resets, each straight from its own flop
//   READY - high once every RNO bit is 1
module gf180mcu_fd_sc_mcu7t5v0__rstseq #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 16,
  parameter int GAP         = 4,
  parameter int NDOM        = 4
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            SWRN,
  output logic [NDOM-1:0] RNO,
  output logic            READY
);

  localparam int MAXV = (STRETCH > GAP) ? STRETCH : GAP;
  localparam int CW   = $clog2(MAXV + 1);
  localparam int IW   = (NDOM > 1) ? $clog2(NDOM) : 1;
  localparam logic [CW-1:0] STR_C = CW'(STRETCH);
  localparam logic [CW-1:0] GAP_C = CW'(GAP);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NDOM-1:0]        rno_q, rno_d;
  logic                   ready_q, ready_d;

  logic          sync;
  logic [CW-1:0] cnt_inc;
  logic [IW-1:0] idx_nxt;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + 1'b1;
  // idx_q holds the most recently released domain.
  assign idx_nxt = idx_q + 1'b1;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync_q  <= '0;
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rno_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rno_q   <= rno_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    // The synchronizer shifts in 1s. SWRN does not affect it.
    sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rno_d   = rno_q;
    ready_d = ready_q;

    if (!SWRN) begin
      // Soft reset wins over any release due on this edge.
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rno_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (sync) begin
            if (cnt_inc == STR_C) begin
              rno_d[0] = 1'b1;
              cnt_d    = '0;
              idx_d    = '0;
              if (NDOM == 1) begin
                state_d = RUN;
                ready_d = 1'b1;
              end else begin
                state_d = RELEASE;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        RELEASE: begin
          if (cnt_inc == GAP_C) begin
            rno_d = rno_q | (NDOM'(1) << idx_nxt);
            cnt_d = '0;
            idx_d = idx_nxt;
            if (int'(idx_nxt) == NDOM - 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RUN:     ;
        default: state_d = HOLD;
      endcase
    end
  end

  assign RNO   = rno_q;
  assign READY = ready_q;

endmodule
